// File: rtl/tpd_pkg.sv
// Shared definitions for the timing-pulse decoder.
//   TP_W          width of the tp1..tp8 pulse bus
//   tpd_state_e   decoder FSM states (HUNT / TRACK / LOCKED)
//   onehot_to_idx classify a pulse sample and return {legal, idx[2:0]}
package tpd_pkg;

  localparam int unsigned TP_W = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } tpd_state_e;

  // A sample is legal only if exactly one bit is set and that bit lies
  // inside the active pulse range. idx is the position of the highest set
  // bit; it is only meaningful when legal is 1.
  function automatic logic [3:0] onehot_to_idx(input logic [TP_W-1:0] tp,
                                               input int unsigned num_pulses);
    logic [3:0] cnt;
    logic [2:0] idx;
    logic       legal;
    cnt = '0;
    idx = '0;
    for (int i = 0; i < TP_W; i++) begin
      if (tp[i]) begin
        cnt = cnt + 4'd1;
        idx = 3'(i);
      end
    end
    legal = (cnt == 4'd1) && (32'(idx) < num_pulses);
    return {legal, idx};
  endfunction

endpackage

// File: rtl/tp_onehot_encoder.sv
// Combinational classifier/encoder for the one-hot timing-pulse bus.
// Ports:
//   tp_i     pulse sample, tp_i[0]=tp1 .. tp_i[7]=tp8
//   legal_o  sample is exactly one pulse within tp1..tpNUM_PULSES
//   idx_o    zero-based index of the pulse (valid when legal_o)
module tp_onehot_encoder
  import tpd_pkg::*;
#(
  parameter int unsigned NUM_PULSES = 7
) (
  input  logic [TP_W-1:0] tp_i,
  output logic            legal_o,
  output logic [2:0]      idx_o
);

  always_comb begin
    {legal_o, idx_o} = onehot_to_idx(tp_i, NUM_PULSES);
  end

endmodule

// File: rtl/timing_pulse_decoder.sv
// Timing-pulse decoder: receive-side partner of the pulse sequence generator.
// Decodes the one-hot tp1..tpNUM_PULSES train into a phase index, checks
// ordering and one-hot integrity, locks after LOCK_CYCLES clean cycles,
// counts completed cycles while locked and reports sequence faults.
// Optional build macro: TPD_STICKY_ERR_EN
//   defined   -> seq_error sets on the first fault and holds until reset
//   undefined -> seq_error pulses for one cycle per fault
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   tp           one-hot pulse train, tp[0]=tp1 .. tp[7]=tp8
//   phase        decoded phase index (meaningful when phase_valid)
//   phase_valid  sample was legal and in order
//   cycle_start  phase 0 decoded while locked
//   cycle_end    last phase decoded while locked
//   locked       synchronised to the pulse train
//   cycle_count  completed cycles while locked, wraps
//   seq_error    fault flag (pulse or sticky)
//   err_count    fault count, saturating
//   fsm_state    debug view of the decoder FSM
// All outputs are registered: tp sampled at edge N is reflected after edge N.
module timing_pulse_decoder
  import tpd_pkg::*;
#(
  parameter int unsigned NUM_PULSES  = 7,
  parameter int unsigned LOCK_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TP_W-1:0]  tp,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             cycle_start,
  output logic             cycle_end,
  output logic             locked,
  output logic [CNT_W-1:0] cycle_count,
  output logic             seq_error,
  output logic [CNT_W-1:0] err_count,
  output tpd_state_e       fsm_state
);

  localparam logic [2:0] LAST_PHASE  = 3'(NUM_PULSES - 1);
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CYCLES);

  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return (p == LAST_PHASE) ? 3'd0 : p + 3'd1;
  endfunction

  logic       tp_legal;
  logic [2:0] tp_idx;

  tp_onehot_encoder #(
    .NUM_PULSES(NUM_PULSES)
  ) u_encoder (
    .tp_i   (tp),
    .legal_o(tp_legal),
    .idx_o  (tp_idx)
  );

  tpd_state_e       state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [3:0]       clean_q, clean_d;
  logic [2:0]       phase_q, phase_d;
  logic             phase_valid_q, phase_valid_d;
  logic             cycle_start_q, cycle_start_d;
  logic             cycle_end_q, cycle_end_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             seq_error_q, seq_error_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             fault;

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    clean_d       = clean_q;
    phase_d       = '0;
    phase_valid_d = 1'b0;
    cycle_start_d = 1'b0;
    cycle_end_d   = 1'b0;
    cycle_count_d = cycle_count_q;
    err_count_d   = err_count_q;
    fault         = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        // Only a clean tp1 acquires; anything else is silently ignored.
        if (tp_legal && (tp_idx == 3'd0)) begin
          state_d       = ST_TRACK;
          exp_d         = next_phase(3'd0);
          phase_valid_d = 1'b1;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (tp_legal && (tp_idx == exp_q)) begin
          phase_d       = tp_idx;
          phase_valid_d = 1'b1;
          exp_d         = next_phase(tp_idx);
          if (state_q == ST_LOCKED) begin
            cycle_start_d = (tp_idx == 3'd0);
            if (tp_idx == LAST_PHASE) begin
              cycle_end_d   = 1'b1;
              cycle_count_d = cycle_count_q + CNT_W'(1);
            end
          end else if (tp_idx == LAST_PHASE) begin
            clean_d = clean_q + 4'd1;
            if (clean_d == LOCK_TARGET) state_d = ST_LOCKED;
          end
        end else begin
          // Illegal or out-of-order sample (including a repeated pulse).
          // The sample is consumed by the fault even if it is a tp1.
          fault   = 1'b1;
          state_d = ST_HUNT;
          exp_d   = 3'd0;
          clean_d = 4'd0;
        end
      end
      default: begin
        state_d = ST_HUNT;
        exp_d   = 3'd0;
        clean_d = 4'd0;
      end
    endcase

    if (fault && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end

`ifdef TPD_STICKY_ERR_EN
    seq_error_d = seq_error_q | fault;
`else
    seq_error_d = fault;
`endif

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      exp_q         <= '0;
      clean_q       <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      cycle_start_q <= 1'b0;
      cycle_end_q   <= 1'b0;
      locked_q      <= 1'b0;
      cycle_count_q <= '0;
      seq_error_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      clean_q       <= clean_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      cycle_start_q <= cycle_start_d;
      cycle_end_q   <= cycle_end_d;
      locked_q      <= locked_d;
      cycle_count_q <= cycle_count_d;
      seq_error_q   <= seq_error_d;
      err_count_q   <= err_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign cycle_start = cycle_start_q;
  assign cycle_end   = cycle_end_q;
  assign locked      = locked_q;
  assign cycle_count = cycle_count_q;
  assign seq_error   = seq_error_q;
  assign err_count   = err_count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_timing_pulse_decoder.sv
// Bench for timing_pulse_decoder (NUM_PULSES=7, LOCK_CYCLES=2, CNT_W=16),
// plus a narrow-counter instance (CNT_W=4) fed the same stimulus so that
// saturation and wrap of the counters can be reached in a short run.
module tb_timing_pulse_decoder;
  import tpd_pkg::*;

  localparam int NP   = 7;
  localparam int LOCK = 2;
  localparam int W    = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tp = 8'h00;

  logic [2:0]  phase, phase_s;
  logic        phase_valid, phase_valid_s;
  logic        cycle_start, cycle_start_s;
  logic        cycle_end, cycle_end_s;
  logic        locked, locked_s;
  logic [15:0] cycle_count;
  logic [3:0]  cycle_count_s;
  logic        seq_error, seq_error_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;
  tpd_state_e  fsm_state, fsm_state_s;

  timing_pulse_decoder #(.NUM_PULSES(NP), .LOCK_CYCLES(LOCK), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .tp(tp), .phase(phase), .phase_valid(phase_valid),
    .cycle_start(cycle_start), .cycle_end(cycle_end), .locked(locked),
    .cycle_count(cycle_count), .seq_error(seq_error), .err_count(err_count),
    .fsm_state(fsm_state));

  timing_pulse_decoder #(.NUM_PULSES(NP), .LOCK_CYCLES(LOCK), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .tp(tp), .phase(phase_s), .phase_valid(phase_valid_s),
    .cycle_start(cycle_start_s), .cycle_end(cycle_end_s), .locked(locked_s),
    .cycle_count(cycle_count_s), .seq_error(seq_error_s), .err_count(err_count_s),
    .fsm_state(fsm_state_s));

  always #5 clk = ~clk;

  // Reference model: synchronised/locked flags, next expected pulse,
  // clean cycle tally and unbounded event totals.
  bit             m_synced, m_locked, m_sticky;
  int             m_next, m_clean, m_cycles, m_errs;
  logic [W-1:0]   exp_q[$];
  int             n_vec, n_err;
  int             gen_ph;

  function automatic logic [W-1:0] obs();
    return {phase_valid ? phase : 3'd0, phase_valid, cycle_start, cycle_end,
            locked, seq_error, cycle_count, err_count};
  endfunction

  task automatic model_reset();
    m_synced = 0; m_locked = 0; m_sticky = 0;
    m_next = 0; m_clean = 0; m_cycles = 0; m_errs = 0;
    gen_ph = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [7:0] s);
    bit legal, fault, e_valid, e_cs, e_ce, e_err;
    int idx;
    logic [2:0] e_phase;
    idx = 0;
    for (int i = 0; i < 8; i++) if (s[i]) idx = i;
    legal = ($countones(s) == 1) && (int'(s) < (1 << NP));
    fault = 0; e_valid = 0; e_cs = 0; e_ce = 0; e_phase = 3'd0;
    if (!m_synced) begin
      if (legal && idx == 0) begin
        m_synced = 1; m_next = 1; e_valid = 1;
      end
    end else if (legal && idx == m_next) begin
      e_valid = 1;
      e_phase = 3'(idx);
      m_next = (idx + 1) % NP;
      if (idx == 0 && m_locked) e_cs = 1;
      if (idx == NP - 1) begin
        if (m_locked) begin
          e_ce = 1;
          m_cycles++;
        end else begin
          m_clean++;
          if (m_clean == LOCK) m_locked = 1;
        end
      end
    end else begin
      fault = 1;
      m_synced = 0; m_locked = 0; m_clean = 0; m_next = 0;
      m_errs++;
    end
    m_sticky = m_sticky | fault;
`ifdef TPD_STICKY_ERR_EN
    e_err = m_sticky;
`else
    e_err = fault;
`endif
    exp_q.push_back({e_phase, e_valid, e_cs, e_ce, m_locked, e_err,
                     16'(m_cycles % 65536), 16'((m_errs > 65535) ? 65535 : m_errs)});
  endtask

  // Drive one sample at the falling edge, sample outputs 1 ns after the
  // following rising edge.
  task automatic step(input logic [7:0] s);
    @(negedge clk);
    reset = 1'b0;
    tp = s;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic next_gen(output logic [7:0] s);
    s = 8'(1 << gen_ph);
    gen_ph = (gen_ph + 1) % NP;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tp = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    tp = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== {W{1'b0}} || fsm_state !== ST_HUNT) begin
      n_err++;
      $display("FAIL reset_state: got %h state %0d want 0 state 0", obs(), fsm_state);
    end
    n_vec++;
    if ({err_count_s, cycle_count_s, locked_s, seq_error_s} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_state_narrow: got %h want 0", {err_count_s, cycle_count_s});
    end
    model_reset();
  endtask

  // Free-running generator from reset: locked must appear right after the
  // second clean tp7, i.e. after sample 2*NP-1 counting from the first tp1.
  task automatic test_lock();
    logic [7:0] s;
    logic [W-1:0] want;
    do_reset();
    for (int k = 0; k < 2 * NP; k++) begin
      next_gen(s);
      step(s);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL lock_seq[%0d]: got %h want %h", k, obs(), want);
      end
      n_vec++;
      if (locked !== (k >= 2 * NP - 1)) begin
        n_err++;
        $display("FAIL lock_time[%0d]: got %b want %b", k, locked, (k >= 2 * NP - 1));
      end
    end
  endtask

  task automatic test_locked_run();
    logic [7:0] s;
    logic [W-1:0] want;
    int ncs, nce;
    test_lock();
    ncs = 0; nce = 0;
    for (int k = 0; k < 10 * NP; k++) begin
      next_gen(s);
      step(s);
      ncs += int'(cycle_start);
      nce += int'(cycle_end);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL locked_run[%0d]: got %h want %h", k, obs(), want);
      end
    end
    n_vec++;
    if (ncs !== 10 || nce !== 10 || cycle_count !== 16'd10) begin
      n_err++;
      $display("FAIL locked_run_counts: got cs=%0d ce=%0d cnt=%0d want 10 10 10",
               ncs, nce, cycle_count);
    end
    n_vec++;
    if (seq_error !== 1'b0 || err_count !== 16'd0) begin
      n_err++;
      $display("FAIL locked_run_errors: got %b/%0d want 0/0", seq_error, err_count);
    end
  endtask

  task automatic test_double_pulse();
    logic [7:0] s;
    logic [W-1:0] want;
    int r;
    test_lock();
    r = $urandom_range(0, NP - 1);
    for (int k = 0; k < r; k++) begin
      next_gen(s);
      step(s);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL dbl_pre[%0d]: got %h want %h", k, obs(), want);
      end
    end
    step(8'b0000_0101);
    gen_ph = (gen_ph + 1) % NP;
    want = exp_q.pop_front();
    n_vec++;
    if (obs() !== want || seq_error !== 1'b1 || err_count !== 16'd1 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL dbl_fault: got %h want %h (err=1 cnt=1 locked=0)", obs(), want);
    end
    for (int k = 0; k < 4 * NP; k++) begin
      next_gen(s);
      step(s);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL dbl_relock[%0d]: got %h want %h", k, obs(), want);
      end
    end
    n_vec++;
    if (locked !== 1'b1 || err_count !== 16'd1) begin
      n_err++;
      $display("FAIL dbl_relocked: got locked=%b err=%0d want 1/1", locked, err_count);
    end
  endtask

  task automatic test_skip();
    logic [7:0] seq [7];
    logic [W-1:0] want;
    logic exp_valid;
    tpd_state_e exp_st;
    seq = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h20, 8'h40, 8'h01};
    test_lock();
    for (int k = 0; k < 7; k++) begin
      step(seq[k]);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL skip_seq[%0d]: got %h want %h", k, obs(), want);
      end
      exp_valid = !(k >= 3 && k <= 5);
      exp_st = (k == 6) ? ST_TRACK : ((k >= 3) ? ST_HUNT : ST_LOCKED);
      n_vec++;
      if (phase_valid !== exp_valid || fsm_state !== exp_st) begin
        n_err++;
        $display("FAIL skip_state[%0d]: got valid=%b st=%0d want %b/%0d",
                 k, phase_valid, fsm_state, exp_valid, exp_st);
      end
    end
  endtask

  task automatic test_tp8();
    logic [7:0] seq [4];
    logic [W-1:0] want;
    seq = '{8'h80, 8'h00, 8'h00, 8'h00};
    test_lock();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) begin
        step(seq[k]);
        want = exp_q.pop_front();
        n_vec++;
        if (obs() !== want) begin
          n_err++;
          $display("FAIL tp8_seq[%0d.%0d]: got %h want %h", pass, k, obs(), want);
        end
      end
      n_vec++;
      if (err_count !== 16'd1 || locked !== 1'b0) begin
        n_err++;
        $display("FAIL tp8_count[%0d]: got err=%0d locked=%b want 1/0", pass, err_count, locked);
      end
    end
  endtask

  // Repeated tp1: acquire, fault, acquire, fault... one fault per two samples.
  task automatic test_saturation();
    logic [W-1:0] want;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(8'h01);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL sat_seq[%0d]: got %h want %h", k, obs(), want);
      end
    end
    n_vec++;
    if (err_count !== 16'd20 || err_count_s !== 4'hF) begin
      n_err++;
      $display("FAIL sat_count: got %0d/%0d want 20/15", err_count, err_count_s);
    end
  endtask

  task automatic test_random();
    logic [7:0] s, last_s;
    logic [W-1:0] want;
    int r;
    do_reset();
    last_s = 8'h00;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) s = 8'($urandom_range(0, 255));
      else if (r < 3) s = last_s;
      else if (r < 4) begin
        gen_ph = (gen_ph + 1) % NP;
        next_gen(s);
      end else next_gen(s);
      last_s = s;
      step(s);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL rand[%0d]: tp=%h got %h want %h", k, s, obs(), want);
      end
      n_vec++;
      if (cycle_count_s !== 4'(m_cycles % 16) ||
          err_count_s !== 4'((m_errs > 15) ? 15 : m_errs)) begin
        n_err++;
        $display("FAIL rand_narrow[%0d]: got cnt=%0d err=%0d want %0d/%0d", k,
                 cycle_count_s, err_count_s, m_cycles % 16, (m_errs > 15) ? 15 : m_errs);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    logic [W-1:0] want;
    test_lock();
    for (int k = 0; k < 5 * NP; k++) begin
      next_gen(s);
      step(s);
      want = exp_q.pop_front();
      n_vec++;
      if (obs() !== want) begin
        n_err++;
        $display("FAIL mid_run[%0d]: got %h want %h", k, obs(), want);
      end
    end
    n_vec++;
    if (cycle_count !== 16'd5) begin
      n_err++;
      $display("FAIL mid_count: got %0d want 5", cycle_count);
    end
    step(8'h03);
    step(8'h01);
    step(8'h02);
    for (int k = 0; k < 3; k++) begin
      want = exp_q.pop_front();
      if (k == 2) begin
        n_vec++;
        if (obs() !== want) begin
          n_err++;
          $display("FAIL mid_fault: got %h want %h", obs(), want);
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
    tp = 8'h04;
    @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== {W{1'b0}} || fsm_state !== ST_HUNT ||
        {cycle_count_s, err_count_s, locked_s, seq_error_s} !== 10'd0) begin
      n_err++;
      $display("FAIL mid_reset: got %h state %0d want 0 state 0", obs(), fsm_state);
    end
    model_reset();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_lock();
    test_locked_run();
    test_double_pulse();
    test_skip();
    test_tp8();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
